// File: rtl/rcf_coeff_loader.sv
// rtl/rcf_coeff_loader.sv - coefficient bank store and load sequencer for the 16-tap RRC FIR
// Optional build macro COEFF_SYM_EN: store half of each bank and stream it mirrored.
module rcf_coeff_loader #(
    parameter int NTAPS  = 16,
    parameter int CW     = 16,
    parameter int NBANKS = 4,
    parameter int BW     = 2,
    parameter int TW     = 4
) (
    input  logic          clk_3p84MHz,
    input  logic          reset,
    input  logic          cfg_wr,
    input  logic [BW-1:0] cfg_bank,
    input  logic [TW-1:0] cfg_tap,
    input  logic [CW-1:0] cfg_data,
    output logic          cfg_rej,
    input  logic          load_req,
    input  logic [BW-1:0] load_bank,
    output logic          load_err,
    output logic          busy,
    output logic          done,
    output logic [BW-1:0] active_bank,
    output logic          coeff_we,
    output logic [CW-1:0] coeff_out
);

`ifdef COEFF_SYM_EN
    localparam int SW = TW - 1;
`else
    localparam int SW = TW;
`endif
    localparam int AW = BW + SW;
    localparam bit BANKS_FULL = (NBANKS >= (1 << BW));

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [CW-1:0] mem [1 << AW];
    logic [1:0]    state;
    logic [TW-1:0] tap;
    logic [BW-1:0] cur_bank;
    logic [SW-1:0] cfg_slot;
    logic [SW-1:0] rd_slot;
    logic          cfg_tap_ok;
    logic          cfg_ok;
    logic          load_ok;

    always_comb begin
        cfg_tap_ok = 1'b1;
        cfg_slot   = '0;
        rd_slot    = '0;
`ifdef COEFF_SYM_EN
        // Upper half of the tap range folds onto the stored lower half.
        cfg_tap_ok = ~cfg_tap[TW-1];
        cfg_slot   = cfg_tap[SW-1:0];
        rd_slot    = tap[TW-1] ? ~tap[SW-1:0] : tap[SW-1:0];
`else
        cfg_slot   = cfg_tap;
        rd_slot    = tap;
`endif
        load_ok = load_req && (state != S_LOAD)
                  && (BANKS_FULL || (int'(load_bank) < NBANKS));
        // The streaming bank is locked only while reads of it are still pending.
        cfg_ok  = cfg_wr && cfg_tap_ok
                  && (BANKS_FULL || (int'(cfg_bank) < NBANKS))
                  && !((state == S_LOAD) && (cfg_bank == cur_bank));
    end

    always_ff @(posedge clk_3p84MHz) begin
        if (!reset) begin
            for (int i = 0; i < (1 << AW); i++) begin
                mem[i] <= '0;
            end
        end else if (cfg_ok) begin
            mem[{cfg_bank, cfg_slot}] <= cfg_data;
        end
    end

    always_ff @(posedge clk_3p84MHz) begin
        if (!reset) begin
            state       <= S_IDLE;
            tap         <= '0;
            cur_bank    <= '0;
            cfg_rej     <= 1'b0;
            load_err    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            active_bank <= '0;
            coeff_we    <= 1'b0;
            coeff_out   <= '0;
        end else begin
            cfg_rej  <= cfg_wr && !cfg_ok;
            load_err <= load_req && !load_ok;
            coeff_we <= (state == S_LOAD);
            busy     <= (state == S_LOAD);
            done     <= (state == S_DONE);
            if (state == S_DONE) begin
                active_bank <= cur_bank;
            end
            if (state == S_LOAD) begin
                coeff_out <= mem[{cur_bank, rd_slot}];
            end
            case (state)
                S_IDLE, S_DONE: begin
                    if (load_ok) begin
                        state    <= S_LOAD;
                        cur_bank <= load_bank;
                        tap      <= TW'(NTAPS - 1);
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    tap <= tap - 1'b1;
                    if (tap == '0) begin
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rcf_coeff_loader.sv
// tb/tb_rcf_coeff_loader.sv - directed self-checking bench for rcf_coeff_loader
module tb_rcf_coeff_loader;

    logic        clk_3p84MHz = 1'b0;
    logic        reset = 1'b0;
    logic        cfg_wr = 1'b0;
    logic [1:0]  cfg_bank = '0;
    logic [3:0]  cfg_tap = '0;
    logic [15:0] cfg_data = '0;
    logic        cfg_rej;
    logic        load_req = 1'b0;
    logic [1:0]  load_bank = '0;
    logic        load_err;
    logic        busy;
    logic        done;
    logic [1:0]  active_bank;
    logic        coeff_we;
    logic [15:0] coeff_out;

    int total = 0;
    int bad = 0;
    logic [15:0] exp_tap [16];

    rcf_coeff_loader dut (
        .clk_3p84MHz(clk_3p84MHz), .reset(reset),
        .cfg_wr(cfg_wr), .cfg_bank(cfg_bank), .cfg_tap(cfg_tap), .cfg_data(cfg_data),
        .cfg_rej(cfg_rej), .load_req(load_req), .load_bank(load_bank), .load_err(load_err),
        .busy(busy), .done(done), .active_bank(active_bank),
        .coeff_we(coeff_we), .coeff_out(coeff_out)
    );

    always #5 clk_3p84MHz = ~clk_3p84MHz;

    task automatic tick;
        @(posedge clk_3p84MHz);
        #1;
    endtask

    task automatic write_coeff(input logic [1:0] b, input logic [3:0] t, input logic [15:0] d,
                               input logic rej_exp);
        cfg_wr = 1'b1; cfg_bank = b; cfg_tap = t; cfg_data = d;
        tick;
        cfg_wr = 1'b0;
        total++;
        if (cfg_rej !== rej_exp) begin
            bad++;
            $display("FAIL write_rej b%0d t%0d: got %b want %b", b, t, cfg_rej, rej_exp);
        end
    endtask

    // Requests bank b, then checks the 16 words against exp_tap plus the done cycle.
    task automatic run_stream(input logic [1:0] b, input string name);
        load_req = 1'b1; load_bank = b;
        tick;
        load_req = 1'b0;
        total++;
        if ({busy, coeff_we} !== 2'b00) begin
            bad++;
            $display("FAIL %s accept_edge: busy/we got %b want 00", name, {busy, coeff_we});
        end
        for (int i = 0; i < 16; i++) begin
            tick;
            total++;
            if ({busy, coeff_we, coeff_out} !== {2'b11, exp_tap[15-i]}) begin
                bad++;
                $display("FAIL %s word%0d: got busy=%b we=%b %h want 1 1 %h",
                         name, i, busy, coeff_we, coeff_out, exp_tap[15-i]);
            end
        end
        tick;
        total++;
        if ({done, busy, coeff_we, active_bank} !== {3'b100, b}) begin
            bad++;
            $display("FAIL %s done_cycle: got done=%b busy=%b we=%b bank=%0d want 1 0 0 %0d",
                     name, done, busy, coeff_we, active_bank, b);
        end
        tick;
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL %s done_width: got %b want 0", name, done);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        tick;
        tick;
        total++;
        if ({cfg_rej, load_err, busy, done, coeff_we} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 00000", {cfg_rej, load_err, busy, done, coeff_we});
        end
        total++;
        if ({active_bank, coeff_out} !== 18'h0) begin
            bad++;
            $display("FAIL reset_data: got bank=%0d coeff=%h want 0 0000", active_bank, coeff_out);
        end
        reset = 1'b1;
        tick;
    endtask

    task automatic test_stream;
        for (int k = 0; k < 16; k++) begin
            write_coeff(2'd1, 4'(k), 16'h0100 + 16'(k), 1'b0);
            exp_tap[k] = 16'h0100 + 16'(k);
        end
        run_stream(2'd1, "stream_bank1");
    endtask

    task automatic test_busy_reject;
        int errs = 0;
        load_req = 1'b1; load_bank = 2'd1;
        tick;
        load_req = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick;
            errs += int'(load_err);
            total++;
            if ({coeff_we, coeff_out} !== {1'b1, 16'h010F - 16'(i)}) begin
                bad++;
                $display("FAIL busy_word%0d: got we=%b %h want 1 %h", i, coeff_we, coeff_out,
                         16'h010F - 16'(i));
            end
            load_req = 1'b0;
            cfg_wr   = 1'b0;
            if (i == 4) begin
                load_req = 1'b1; load_bank = 2'd2;
            end
            if (i == 6) begin
                cfg_wr = 1'b1; cfg_bank = 2'd1; cfg_tap = 4'd3; cfg_data = 16'h5555;
            end
            if (i == 7) begin
                total++;
                if (cfg_rej !== 1'b1) begin
                    bad++;
                    $display("FAIL busy_same_bank_rej: got %b want 1", cfg_rej);
                end
                cfg_wr = 1'b1; cfg_bank = 2'd0; cfg_tap = 4'd3; cfg_data = 16'h7FFF;
            end
            if (i == 8) begin
                total++;
                if (cfg_rej !== 1'b0) begin
                    bad++;
                    $display("FAIL busy_other_bank_rej: got %b want 0", cfg_rej);
                end
            end
        end
        tick;
        total++;
        if ({done, active_bank} !== 3'b101) begin
            bad++;
            $display("FAIL busy_done: got done=%b bank=%0d want 1 1", done, active_bank);
        end
        total++;
        if (errs != 1) begin
            bad++;
            $display("FAIL load_err_pulses: got %0d want 1", errs);
        end
        tick;
    endtask

    task automatic test_bank_contents;
        for (int k = 0; k < 16; k++) exp_tap[k] = 16'h0;
        exp_tap[3] = 16'h7FFF;
        run_stream(2'd0, "bank0_after_write");
        for (int k = 0; k < 16; k++) exp_tap[k] = 16'h0100 + 16'(k);
        run_stream(2'd1, "bank1_tap3_kept");
    endtask

    task automatic test_write_on_load;
        cfg_wr = 1'b1; cfg_bank = 2'd2; cfg_tap = 4'd15; cfg_data = 16'h2F2F;
        load_req = 1'b1; load_bank = 2'd2;
        tick;
        cfg_wr = 1'b0; load_req = 1'b0;
        total++;
        if (cfg_rej !== 1'b0) begin
            bad++;
            $display("FAIL same_edge_write_rej: got %b want 0", cfg_rej);
        end
        tick;
        total++;
        if ({coeff_we, coeff_out} !== {1'b1, 16'h2F2F}) begin
            bad++;
            $display("FAIL same_edge_first_word: got we=%b %h want 1 2f2f", coeff_we, coeff_out);
        end
        for (int i = 0; i < 16; i++) tick;
    endtask

    task automatic test_back_to_back;
        for (int k = 0; k < 16; k++) write_coeff(2'd0, 4'(k), 16'h0A00 + 16'(k), 1'b0);
        load_req = 1'b1; load_bank = 2'd0;
        tick;
        load_req = 1'b0;
        for (int i = 0; i < 16; i++) tick;
        load_req = 1'b1; load_bank = 2'd0;
        tick;
        load_req = 1'b0;
        total++;
        if ({done, coeff_we, load_err} !== 3'b100) begin
            bad++;
            $display("FAIL b2b_done_cycle: got done=%b we=%b err=%b want 1 0 0",
                     done, coeff_we, load_err);
        end
        for (int i = 0; i < 16; i++) begin
            tick;
            total++;
            if ({coeff_we, coeff_out} !== {1'b1, 16'h0A0F - 16'(i)}) begin
                bad++;
                $display("FAIL b2b_word%0d: got we=%b %h want 1 %h", i, coeff_we, coeff_out,
                         16'h0A0F - 16'(i));
            end
        end
        tick;
        total++;
        if ({done, coeff_we} !== 2'b10) begin
            bad++;
            $display("FAIL b2b_second_done: got done=%b we=%b want 1 0", done, coeff_we);
        end
        tick;
    endtask

    task automatic test_reset_midstream;
        load_req = 1'b1; load_bank = 2'd1;
        tick;
        load_req = 1'b0;
        for (int i = 0; i < 8; i++) tick;
        reset = 1'b0;
        tick;
        total++;
        if ({coeff_we, busy, done} !== 3'b000) begin
            bad++;
            $display("FAIL midreset_outputs: got we=%b busy=%b done=%b want 0 0 0",
                     coeff_we, busy, done);
        end
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick;
            total++;
            if ({done, coeff_we} !== 2'b00) begin
                bad++;
                $display("FAIL midreset_no_done%0d: got done=%b we=%b want 0 0", i, done, coeff_we);
            end
        end
        for (int k = 0; k < 16; k++) exp_tap[k] = 16'h0;
        run_stream(2'd1, "bank1_cleared");
    endtask

`ifdef COEFF_SYM_EN
    task automatic test_symmetric;
        for (int k = 0; k < 8; k++) write_coeff(2'd3, 4'(k), 16'(k + 1), 1'b0);
        write_coeff(2'd3, 4'd9, 16'hDEAD, 1'b1);
        for (int k = 0; k < 16; k++) exp_tap[k] = (k < 8) ? 16'(k + 1) : 16'(16 - k);
        run_stream(2'd3, "sym_bank3");
    endtask
`endif

    initial begin
        test_reset;
`ifdef COEFF_SYM_EN
        test_symmetric;
`else
        test_stream;
        test_busy_reject;
        test_bank_contents;
        test_write_on_load;
        test_back_to_back;
        test_reset_midstream;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
